// File: rtl/sdf_bitrev_reorder_if.sv
// Stream bundle between the last SDF FFT stage, the reorder buffer and the
// downstream consumer. Input side carries bit-reversed samples; output side
// carries natural-order samples plus a frame-start pulse.
interface sdf_bitrev_reorder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             do_start;

  // Producer of the bit-reversed stream / consumer of the reordered stream
  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_start
  );

  // Reorder buffer itself
  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_start
  );

endinterface

// File: rtl/sdf_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the radix-2^2 SDF FFT.
// Ping-pong pair of N-word banks: one bank fills in arrival order while the
// other is read out at bit-reversed addresses, so back-to-back frames stream
// through without a stall. Latency from first accepted sample to output
// index 0 is N+1 cycles.
// Optional build macro BITREV_LP_EN: when defined, do_re/do_im are forced to
// zero on every cycle with do_en low; otherwise they hold the last sample.
module sdf_bitrev_reorder #(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  sdf_bitrev_reorder_if.slave bus
);

  localparam int unsigned LOG_N  = $clog2(N);
  localparam int unsigned WORD_W = 2 * WIDTH;
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_e;

  // Storage: two banks of N complex words, {re, im}
  logic [WORD_W-1:0] mem_q [2][N];

  logic [LOG_N-1:0] wr_count_q, wr_count_d;
  logic             wr_bank_q, wr_bank_d;
  logic             frame_done_c;

  state_e           state_q;
  logic [LOG_N-1:0] rd_count_q;
  logic             rd_bank_q;
  logic [LOG_N-1:0] rd_addr_c;
  logic [WORD_W-1:0] rd_word_c;

  logic             do_en_q;
  logic             do_start_q;
  logic [WIDTH-1:0] do_re_q;
  logic [WIDTH-1:0] do_im_q;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG_N; i++) begin
      r[i] = a[LOG_N-1-i];
    end
    return r;
  endfunction

  // Write-side next state: advance on valid, wrap and flip bank on the last
  // sample, and drop any partial frame the moment di_en falls early.
  always_comb begin
    wr_count_d   = wr_count_q;
    wr_bank_d    = wr_bank_q;
    frame_done_c = 1'b0;
    if (bus.di_en) begin
      wr_count_d = wr_count_q + LOG_N'(1);
      if (wr_count_q == LAST_IDX) begin
        frame_done_c = 1'b1;
        wr_bank_d    = ~wr_bank_q;
      end
    end else begin
      wr_count_d = '0;
    end
  end

  // Write-side counter and bank select
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_count_q <= '0;
      wr_bank_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      wr_bank_q  <= wr_bank_d;
    end
  end

  // Sample storage, linear address in arrival order; contents survive reset
  always_ff @(posedge clock) begin
    if (reset_n && bus.di_en) begin
      mem_q[wr_bank_q][wr_count_q] <= {bus.di_re, bus.di_im};
    end
  end

  // Combinational read at the bit-reversed address of the natural index
  always_comb begin
    rd_addr_c = bitrev(rd_count_q);
    rd_word_c = mem_q[rd_bank_q][rd_addr_c];
  end

  // Read FSM and registered output stage
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_count_q <= '0;
      rd_bank_q  <= 1'b0;
      do_en_q    <= 1'b0;
      do_start_q <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
    end else begin
      do_en_q    <= (state_q == READ);
      do_start_q <= (state_q == READ) && (rd_count_q == '0);
      if (state_q == READ) begin
        do_re_q <= rd_word_c[WORD_W-1:WIDTH];
        do_im_q <= rd_word_c[WIDTH-1:0];
      end else begin
`ifdef BITREV_LP_EN
        do_re_q <= '0;
        do_im_q <= '0;
`else
        do_re_q <= do_re_q;
        do_im_q <= do_im_q;
`endif
      end

      case (state_q)
        IDLE: begin
          if (frame_done_c) begin
            state_q    <= READ;
            rd_bank_q  <= wr_bank_q;
            rd_count_q <= '0;
          end
        end
        READ: begin
          rd_count_q <= rd_count_q + LOG_N'(1);
          if (rd_count_q == LAST_IDX) begin
            // A frame finishing right now chains straight into the next read
            if (frame_done_c) begin
              rd_bank_q <= wr_bank_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.do_en    = do_en_q;
  assign bus.do_start = do_start_q;
  assign bus.do_re    = do_re_q;
  assign bus.do_im    = do_im_q;

endmodule

// File: doc/sdf_bitrev_reorder.md
# sdf_bitrev_reorder

Reorders the bit-reversed output stream of the radix-2^2 SDF FFT pipeline into natural frequency order. It sits directly after the last SDF stage and consumes the same `di_en`/`di_re`/`di_im` stream that the pipeline emits, one complex sample per clock. It re-emits each frame on a `do_en`/`do_re`/`do_im` stream in index order 0..N-1. A ping-pong pair of N-word banks lets it accept back-to-back frames with no stall.

## Interface
- `N`, 64: FFT points per frame; power of two, >= 4.
- `WIDTH`, 16: bit width of each real/imag component.
- `clock`  in  1  master clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `di_en`  in  1  input sample valid; high for exactly N consecutive cycles per frame.
- `di_re`  in  WIDTH  input sample, real part, bit-reversed order.
- `di_im`  in  WIDTH  input sample, imaginary part.
- `do_en`  out  1  output sample valid.
- `do_re`  out  WIDTH  output sample, real part, natural order.
- `do_im`  out  WIDTH  output sample, imaginary part.
- `do_start`  out  1  one-cycle pulse coincident with output index 0 of each frame.

## Operation
- LOG_N = log2(N). Storage is 2 banks × N words × 2·WIDTH bits.
- Write side:
  - `wr_count` (LOG_N bits) and `wr_bank` (1 bit).
  - On each cycle with `di_en`=1, store the sample at linear address `wr_count` in bank `wr_bank`, then increment `wr_count`.
  - When `wr_count`=N-1 and `di_en`=1, the frame is complete: `wr_count` wraps to 0, `wr_bank` toggles, and a read of the just-filled bank is started.
  - If `di_en`=0 while `wr_count`≠0, the partial frame is discarded. `wr_count` returns to 0, `wr_bank` is unchanged, and nothing is output for that frame.
- Read side, with states IDLE and READ:
  - IDLE→READ on frame complete. `rd_bank` is the bank just filled and `rd_count` is 0.
  - In READ, each cycle reads address bitrev(`rd_count`) from `rd_bank`, registers the result to `do_re`/`do_im`, and increments `rd_count`.
  - READ→IDLE after `rd_count`=N-1.
  - If a frame completes in the same cycle as `rd_count`=N-1, the block stays in READ: the new bank is loaded and `rd_count` becomes 0. This produces a continuous output stream.
- Bank conflict cannot occur: the next frame needs at least N cycles to complete, and a read takes exactly N cycles. No backpressure exists.
- Data passes through unmodified. There is no arithmetic and no width change.

## Timing
- Reset (`reset_n`=0 at an edge):
  - `do_en`=0, `do_start`=0, `do_re`=`do_im`=0.
  - `wr_count`=`rd_count`=0, `wr_bank`=0, state IDLE.
  - Stored data is discarded, but memory contents are not cleared.
- Reset mid-frame or mid-read: outputs are 0 on the next cycle. The next full frame after reset is handled correctly.
- Latency:
  - Let the first input sample of a frame be accepted at edge t0.
  - The frame completes at t0+N-1.
  - `do_en` rises at t0+N+1 and stays high N cycles.
  - Natural index i is valid at t0+N+1+i.
  - `do_start` is high at t0+N+1 only.
- Back-to-back input frames (no `di_en` gap) produce `do_en` continuously high, with one `do_start` every N cycles.
- Read-side memory access is combinational, and the output register adds 1 cycle.

## Configuration
- `BITREV_LP_EN`:
  - Defined: `do_re`/`do_im` are driven to 0 on every cycle with `do_en`=0. This reduces toggling downstream.
  - Undefined: `do_re`/`do_im` hold the last valid sample while `do_en`=0.
- `do_en`/`do_start` timing is identical in both builds.

## Test plan
- **Single frame** (N=64, WIDTH=16): input sample k = (bitrev6(k), −bitrev6(k)). Required: `do_re` = 0,1,…,63 and `do_im` = 0,−1,…,−63 at t0+65…t0+128. `do_start` high only at t0+65.
- **Three back-to-back frames** with distinct ramps. Required: `do_en` high for 192 consecutive cycles. Each frame is in natural order, with `do_start` at offsets 0, 64 and 128.
- **Aborted frame**: `di_en` drops after 20 samples, then a full ramp frame follows. Required: no output from the aborted frame, and the full frame is output correctly.
- **Reset during output**: `reset_n`=0 for 1 cycle at read index 10. Required: `do_en`=0 and data=0 the next cycle with no resumption. The following frame is correct.
- **N=4 parameter**: input a,b,c,d. Required: output a,c,b,d starting 5 cycles after a.
- **Build with `BITREV_LP_EN`**: repeat the single-frame test. Required: data=0 whenever `do_en`=0. Without the macro, data holds 63/−63 after the frame.
